// File: rtl/sq_prod_accum.sv
// Squaring-pass sequencer and column accumulator.
// Steps SQ_STATE 1..5 to the operand selector, follows each issued state
// through a MUL_LAT-deep tag pipe, and folds the returning M1/M2 lane
// products into a 2*129-digit column accumulator (cross terms doubled).
module sq_prod_accum #(
  parameter int NSEG    = 4,
  parameter int LANES   = 33,
  parameter int PROD_W  = 36,
  parameter int NCOL    = 258,
  parameter int ACC_W   = 48,
  parameter int MUL_LAT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic [4:0]                SQ_STATE,
  input  logic [LANES*PROD_W-1:0]   mul1_p,
  input  logic [LANES*PROD_W-1:0]   mul2_p,
  output logic                      busy,
  output logic                      done,
  output logic [NCOL*ACC_W-1:0]     acc_col
);

  localparam int SEGW  = $clog2(NSEG);
  localparam int SEG_D = 32;               // digits per segment (column stride)
  localparam int CW    = $clog2(NCOL);
  localparam logic [SEGW-1:0] TOP = SEGW'(NSEG - 1);  // only segment with a 33rd lane

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                   r_st;
  logic [4:0]               r_sq;
  logic                     r_busy;
  logic                     r_done;
  logic [MUL_LAT-1:0][4:0]  r_tag;
  logic [ACC_W-1:0]         r_acc     [NCOL];
  logic [ACC_W-1:0]         w_acc_nxt [NCOL];
  logic [4:0]               w_tag;
  logic                     w_go;
  logic [SEGW-1:0]          w_a1, w_b1, w_a2, w_b2;

  // A start is refused in the done cycle so passes are spaced MUL_LAT+7 apart.
  assign w_go  = (r_st == S_IDLE) && start && !r_done;
  assign w_tag = r_tag[MUL_LAT-1];

  assign SQ_STATE = r_sq;
  assign busy     = r_busy;
  assign done     = r_done;

  // Segment pairs {a1,b1,a2,b2} multiplied by M1/M2 for each state.
  function automatic logic [4*SEGW-1:0] seg_pairs(input logic [4:0] s);
    case (s)
      5'd1:    seg_pairs = {SEGW'(3), SEGW'(3), SEGW'(3), SEGW'(2)};
      5'd2:    seg_pairs = {SEGW'(2), SEGW'(2), SEGW'(3), SEGW'(1)};
      5'd3:    seg_pairs = {SEGW'(3), SEGW'(0), SEGW'(2), SEGW'(1)};
      5'd4:    seg_pairs = {SEGW'(1), SEGW'(1), SEGW'(2), SEGW'(0)};
      5'd5:    seg_pairs = {SEGW'(1), SEGW'(0), SEGW'(0), SEGW'(0)};
      default: seg_pairs = '0;
    endcase
  endfunction

  // Product zero-extended to column width, doubled for cross terms.
  function automatic logic [ACC_W-1:0] wterm(input logic [PROD_W-1:0] p, input logic dbl);
    wterm = ACC_W'(p) << dbl;
  endfunction

  // Pass sequencer: IDLE -> ISSUE (states 1..5) -> DRAIN until state 5 lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st   <= S_IDLE;
      r_sq   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_st)
        S_IDLE: if (w_go) begin
          r_sq   <= 5'd1;
          r_busy <= 1'b1;
          r_st   <= S_ISSUE;
        end
        S_ISSUE: if (r_sq == 5'd5) begin
          r_sq <= '0;
          r_st <= S_DRAIN;
        end else begin
          r_sq <= r_sq + 5'd1;
        end
        S_DRAIN: if (w_tag == 5'd5) begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_st   <= S_IDLE;
        end
        default: r_st <= S_IDLE;
      endcase
    end
  end

  // Tag pipe mirrors the multiplier latency; its output qualifies the products.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag <= '0;
    end else begin
      r_tag[0] <= r_sq;
      for (int k = 1; k < MUL_LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  // Next column sums: both banks add into the same image so colliding columns take both.
  always_comb begin : acc_upd
    logic [CW-1:0] idx;
    idx       = '0;
    w_acc_nxt = r_acc;
    {w_a1, w_b1, w_a2, w_b2} = seg_pairs(w_tag);
    for (int j = 0; j < LANES; j++) begin
      if (j < LANES - 1 || w_a1 == TOP || w_b1 == TOP) begin
        idx = CW'(SEG_D * (int'(w_a1) + int'(w_b1)) + j);
        w_acc_nxt[idx] = w_acc_nxt[idx] + wterm(mul1_p[j*PROD_W +: PROD_W], w_a1 != w_b1);
      end
      if (j < LANES - 1 || w_a2 == TOP || w_b2 == TOP) begin
        idx = CW'(SEG_D * (int'(w_a2) + int'(w_b2)) + j);
        w_acc_nxt[idx] = w_acc_nxt[idx] + wterm(mul2_p[j*PROD_W +: PROD_W], w_a2 != w_b2);
      end
    end
  end

  // Accumulator: cleared on an accepted start, updated only under a non-zero tag.
  always_ff @(posedge clk) begin
    if (rst || w_go) begin
      for (int c = 0; c < NCOL; c++) r_acc[c] <= '0;
    end else if (w_tag != 5'd0) begin
      r_acc <= w_acc_nxt;
    end
  end

  for (genvar c = 0; c < NCOL; c++) begin : g_out
    assign acc_col[c*ACC_W +: ACC_W] = r_acc[c];
  end

endmodule

// File: tb/tb_sq_prod_accum.sv
// Randomised bench for sq_prod_accum with a scoreboard of expected column sums.
module tb_sq_prod_accum;
  localparam int LANES = 33, PROD_W = 36, NCOL = 258, ACC_W = 48, MUL_LAT = 4;
  localparam int NCYC = 2048;

  logic clk, rst, start, busy, done;
  logic [4:0] SQ_STATE;
  logic [LANES*PROD_W-1:0] mul1_p, mul2_p;
  logic [NCOL*ACC_W-1:0] acc_col;

  sq_prod_accum #(.NSEG(4), .LANES(LANES), .PROD_W(PROD_W), .NCOL(NCOL),
                  .ACC_W(ACC_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .SQ_STATE(SQ_STATE),
    .mul1_p(mul1_p), .mul2_p(mul2_p), .busy(busy), .done(done), .acc_col(acc_col));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  bit [4:0] exp_sq   [NCYC];
  bit       exp_busy [NCYC];
  bit       exp_done [NCYC];
  bit       mon_en = 1'b0;
  longint unsigned accq[$];   // NCOL expected columns per pass, in column order

  // Segment pairs per state (index 0 = state 1), as multiplied by each bank.
  int a1 [5] = '{3, 2, 3, 1, 1};
  int b1 [5] = '{3, 2, 0, 1, 0};
  int a2 [5] = '{3, 3, 2, 2, 0};
  int b2 [5] = '{2, 1, 1, 0, 0};

  logic [PROD_W-1:0] p1 [5][LANES];
  logic [PROD_W-1:0] p2 [5][LANES];

  function automatic logic [PROD_W-1:0] rnd36();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[PROD_W-1:0];
  endfunction

  // Cycle-by-cycle protocol and completion scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (SQ_STATE !== exp_sq[cyc]) begin
        failures++;
        $display("FAIL sq_state cyc=%0d got=%0d exp=%0d", cyc, SQ_STATE, exp_sq[cyc]);
      end
      checks++;
      if (busy !== exp_busy[cyc]) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%0b exp=%0b", cyc, busy, exp_busy[cyc]);
      end
      checks++;
      if (done !== exp_done[cyc]) begin
        failures++;
        $display("FAIL done cyc=%0d got=%0b exp=%0b", cyc, done, exp_done[cyc]);
      end
      if (done === 1'b1) begin
        checks++;
        if (accq.size() < NCOL) begin
          failures++;
          $display("FAIL acc_queue cyc=%0d got=%0d entries exp>=%0d", cyc, accq.size(), NCOL);
        end else begin
          int bad, first;
          logic [ACC_W-1:0] fa, fe;
          bad = 0; first = -1; fa = '0; fe = '0;
          for (int c = 0; c < NCOL; c++) begin
            longint unsigned e;
            logic [ACC_W-1:0] e48;
            e = accq.pop_front();
            e48 = e[ACC_W-1:0];
            if (acc_col[c*ACC_W +: ACC_W] !== e48) begin
              if (bad == 0) begin
                first = c; fa = acc_col[c*ACC_W +: ACC_W]; fe = e48;
              end
              bad++;
            end
          end
          if (bad != 0) begin
            failures++;
            $display("FAIL acc_col cyc=%0d bad_cols=%0d col=%0d got=%0h exp=%0h",
                     cyc, bad, first, fa, fe);
          end
        end
      end
    end
  end

  // Drive lane products for state st (0 = random noise that must be ignored).
  task automatic drive_mul(input int st);
    for (int j = 0; j < LANES; j++) begin
      mul1_p[j*PROD_W +: PROD_W] = (st == 0) ? rnd36() : p1[st-1][j];
      mul2_p[j*PROD_W +: PROD_W] = (st == 0) ? rnd36() : p2[st-1][j];
    end
  endtask

  // Reference: column sums straight from the pair table and weighting rules.
  task automatic push_model();
    longint unsigned e [NCOL];
    for (int c = 0; c < NCOL; c++) e[c] = 0;
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < LANES; j++) begin
        if (j < 32 || a1[k] == 3 || b1[k] == 3)
          e[32*(a1[k]+b1[k]) + j] += longint'(p1[k][j]) * ((a1[k] == b1[k]) ? 1 : 2);
        if (j < 32 || a2[k] == 3 || b2[k] == 3)
          e[32*(a2[k]+b2[k]) + j] += longint'(p2[k][j]) * ((a2[k] == b2[k]) ? 1 : 2);
      end
    for (int c = 0; c < NCOL; c++) accq.push_back(e[c] & ((64'd1 << ACC_W) - 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); start = 1'b0; drive_mul(0);
    end
  endtask

  task automatic chk_col(input string nm, input int c, input longint unsigned v);
    checks++;
    if (acc_col[c*ACC_W +: ACC_W] !== v[ACC_W-1:0]) begin
      failures++;
      $display("FAIL %s col=%0d got=%0d exp=%0d", nm, c, acc_col[c*ACC_W +: ACC_W], v);
    end
  endtask

  // mode: 0 random, 1 all zero, 2 tag-1 lane-0 ones, 3 tag-2 lane-32 fives.
  // abort: assert rst (together with start) three cycles into the pass.
  task automatic do_pass(input int mode, input bit abort);
    int t, st;
    @(negedge clk);
    t = cyc; start = 1'b1; drive_mul(0);
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < LANES; j++) begin
        p1[k][j] = (mode == 0) ? rnd36() : '0;
        p2[k][j] = (mode == 0) ? rnd36() : '0;
      end
    if (mode == 2) begin p1[0][0] = 36'd1; p2[0][0] = 36'd1; end
    if (mode == 3) begin p1[1][32] = 36'd5; p2[1][32] = 36'd5; end
    push_model();
    for (int k = 1; k <= 5; k++) exp_sq[t+k] = 5'(k);
    for (int i = 1; i <= MUL_LAT + 5; i++) exp_busy[t+i] = 1'b1;
    exp_done[t+MUL_LAT+6] = 1'b1;
    for (int i = 1; i <= MUL_LAT + 6; i++) begin
      @(negedge clk);
      if (abort && i == 3) begin
        rst = 1'b1; start = 1'b1; drive_mul(0);
        for (int c = t + 4; c < NCYC; c++) begin
          exp_sq[c] = '0; exp_busy[c] = 1'b0; exp_done[c] = 1'b0;
        end
        for (int c = 0; c < NCOL; c++) void'(accq.pop_back());
        @(negedge clk);
        rst = 1'b0; start = 1'b0; drive_mul(0);
        for (int c = 0; c < NCOL; c++) chk_col("abort_clear", c, 0);
        return;
      end
      start = 1'($urandom_range(0, 1));
      st = i - MUL_LAT;
      drive_mul((st >= 1 && st <= 5) ? st : 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mul1_p = '0; mul2_p = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (SQ_STATE !== 5'd0 || busy !== 1'b0 || done !== 1'b0 || acc_col !== '0) begin
      failures++;
      $display("FAIL reset_state sq=%0d busy=%0b done=%0b acc_nonzero=%0b exp=0,0,0,0",
               SQ_STATE, busy, done, (acc_col != '0));
    end
    rst = 1'b0;
    mon_en = 1'b1;
    idle(2);

    do_pass(1, 1'b0);
    do_pass(2, 1'b0);
    chk_col("tag1_col192", 192, 1);
    chk_col("tag1_col160", 160, 2);
    idle(1);
    do_pass(3, 1'b0);
    chk_col("tag2_col128", 128, 0);
    chk_col("tag2_col160", 160, 10);
    idle(2);
    for (int n = 0; n < 8; n++) do_pass(0, 1'b0);
    idle(3);
    do_pass(0, 1'b1);
    do_pass(0, 1'b0);
    do_pass(0, 1'b0);
    idle(MUL_LAT + 8);

    checks++;
    if (accq.size() != 0) begin
      failures++;
      $display("FAIL leftover_passes got=%0d entries exp=0", accq.size());
    end
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
